// File: rtl/fpu_uni_pack.sv
// fpu_uni_pack: normalises an FPALU unified-format result and packs it as
// {sgn, exp[5:0], man[21:0]} behind valid/ready handshakes on both sides.
// Optional build macro FPU_PACK_FLUSH_EN: when defined, results that would
// leave normalisation as denormals are flushed to signed zero.
module fpu_uni_pack #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sgn,
  input  logic [5:0]  in_exp,
  input  logic [21:0] in_man_dn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [28:0] out_word,
  output logic        out_zero,
  output logic        out_denorm
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic [5:0]  exp_q, exp_d;
  logic [21:0] man_q, man_d;
  logic        out_valid_q, out_valid_d;
  logic [28:0] out_word_q, out_word_d;
  logic        out_zero_q, out_zero_d;
  logic        out_denorm_q, out_denorm_d;
  logic [5:0]  lz;
  logic [5:0]  shamt;

  // Leading-zero count of the working mantissa (22 when it is zero).
  always_comb begin
    lz = 6'd22;
    for (int i = 0; i < 22; i++) begin
      if (man_q[i]) lz = 6'(21 - i);
    end
  end

  // Per-cycle shift: bounded by the zero count, STEP and the exponent so the
  // exponent bottoms out at 0 instead of wrapping.
  always_comb begin
    shamt = lz;
    if (STEP_W < shamt) shamt = STEP_W;
    if (exp_q < shamt) shamt = exp_q;
  end

  // Next-state and datapath: capture, iterative normalise, hold until taken.
  always_comb begin
    state_d      = state_q;
    sgn_d        = sgn_q;
    exp_d        = exp_q;
    man_d        = man_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    out_zero_d   = out_zero_q;
    out_denorm_d = out_denorm_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sgn_d   = in_sgn;
          exp_d   = in_exp;
          man_d   = in_man_dn;
          state_d = NORM;
        end
      end
      NORM: begin
        if (man_q == 22'd0 || man_q[21] || exp_q == 6'd0) begin
          // Zero mantissa collapses to signed zero; sign is kept.
          if (man_q == 22'd0) exp_d = 6'd0;
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_word_d   = {sgn_q, exp_d, man_d};
          out_zero_d   = (man_d == 22'd0);
          out_denorm_d = (exp_d == 6'd0) && (man_d != 22'd0);
`ifdef FPU_PACK_FLUSH_EN
          if (exp_d == 6'd0 && man_d != 22'd0) begin
            out_word_d   = {sgn_q, 28'd0};
            out_zero_d   = 1'b1;
            out_denorm_d = 1'b0;
          end
`endif
        end else begin
          man_d = man_q << shamt;
          exp_d = exp_q - shamt;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sgn_q        <= 1'b0;
      exp_q        <= 6'd0;
      man_q        <= 22'd0;
      out_valid_q  <= 1'b0;
      out_word_q   <= 29'd0;
      out_zero_q   <= 1'b0;
      out_denorm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sgn_q        <= sgn_d;
      exp_q        <= exp_d;
      man_q        <= man_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_zero_q   <= out_zero_d;
      out_denorm_q <= out_denorm_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_zero   = out_zero_q;
  assign out_denorm = out_denorm_q;

endmodule

// File: doc/fpu_uni_pack.md
Name: fpu_uni_pack

Overview:
- Result-side counterpart to the FPALU operand path.
- Accepts one unified-format FPALU result per transaction (sign, 6-bit exponent, 22-bit left-aligned denormalised mantissa).
- Normalises the mantissa iteratively and packs a 29-bit word: bit 28 sign, 27:22 exponent, 21:0 mantissa.
- Sits between FPALU dout_uni_y_* and the register-file/writeback path, with valid/ready handshakes on both sides.

Parameters:
- STEP, 4, maximum left-shift distance per NORM cycle (legal range 1..22).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  result word present on in_*.
- in_ready  output  1  block can accept a result.
- in_sgn  input  1  result sign.
- in_exp  input  6  result exponent.
- in_man_dn  input  22  result mantissa, left-aligned, possibly denormal.
- out_valid  output  1  packed result is valid.
- out_ready  input  1  consumer accepts the packed result.
- out_word  output  29  packed result {sgn, exp, man}.
- out_zero  output  1  result is zero (mantissa 0).
- out_denorm  output  1  result exponent is 0 with nonzero mantissa.

Behaviour:
- States: IDLE, NORM, DONE. Internal registers: sgn_r, exp_r[5:0], man_r[21:0].
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - out_valid=0, out_word=0, out_zero=0, out_denorm=0; internal registers cleared.
- in_ready = (state==IDLE), combinational. It is 1 while in reset.
- IDLE: on in_valid & in_ready at an edge, capture in_sgn, in_exp and in_man_dn, then go to NORM.
- NORM (one evaluation per cycle, in priority order):
  - man_r==0: exp_r<=0, go to DONE. Sign is preserved, giving signed zero.
  - man_r[21]==1 or exp_r==0: go to DONE.
  - Otherwise, with lz = leading-zero count of man_r: s = min(lz, STEP, exp_r); man_r <<= s (zero-fill); exp_r -= s; stay in NORM.
- Exponent arithmetic never wraps. exp_r stops at 0, which leaves a denormal.
- On the NORM->DONE edge:
  - out_word <= {sgn_r, exp_r, man_r} as the registers stand after that cycle's evaluation.
  - out_zero <= (man==0).
  - out_denorm <= (exp==0 & man!=0).
  - out_valid <= 1.
- DONE: out_valid and all out_* are held stable until out_valid & out_ready at an edge. Then out_valid <= 0 and state goes to IDLE.
  - No same-cycle re-accept: in_ready is 0 in DONE.
  - Minimum one idle cycle between transactions.
- Latency, counted from the accept edge to the first cycle with out_valid=1: 2 + N cycles, where N = number of shifting NORM cycles. N=0 for an already-normalised input.
- in_valid while not in IDLE is ignored. No data is captured.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-NORM or mid-DONE aborts the transaction; the result is lost.

Optional Feature:
- Macro: FPU_PACK_FLUSH_EN.
- Defined: any result that would leave NORM with exp==0 and man!=0 is flushed to signed zero.
  - out_word = {sgn, 6'd0, 22'd0}, out_zero=1, out_denorm=0.
  - Latency is unchanged.
- Undefined: denormals are emitted as-is, with out_denorm=1.

Test Plan:
- Normalised input, STEP=4: sgn=0, exp=32, man=22'h200000 -> out_word=29'h08200000, zero=0, denorm=0, out_valid 2 cycles after the accept edge.
- Multi-step shift: exp=20, man=22'h000400 (lz=11) -> shifts of 4, 4, 3 -> out_word=29'h02600000, out_valid 5 cycles after accept.
- Exponent-limited shift: sgn=1, exp=3, man=22'h000001 -> one shift of 3, exp hits 0.
  - Macro off: out_word=29'h10000008, out_denorm=1.
  - FPU_PACK_FLUSH_EN on: out_word=29'h10000000, out_zero=1, out_denorm=0.
- Zero input: sgn=1, exp=45, man=0 -> out_word=29'h10000000, out_zero=1, out_valid 2 cycles after accept.
- Backpressure: out_ready held low 5 cycles after out_valid -> out_word, out_zero and out_denorm stable; in_ready=0; a held in_valid with new data is not captured; release out_ready -> handshake completes, in_ready=1 next cycle.
- Reset mid-NORM: drop rst_n during the second shift of the multi-step case -> out_valid=0 and out_word=0 immediately (asynchronous); after release, in_ready=1 and a new transaction completes normally.
